// File: rtl/fib_stream_check.sv
// fib_stream_check
//
// Receive-side checker for a Fibonacci term stream. A run starts with a
// one-cycle start pulse. The checker then accepts one term per qualified
// cycle, regenerates the expected sequence internally, and compares the two.
// All term arithmetic wraps modulo 2^DATA_W.
//
// Handshake: din/din_valid is a valid-only stream with no backpressure. A term
// is consumed on every rising edge where en, din_valid and the RUN state are
// all true. Gaps in din_valid are allowed. While en is low, every register
// holds and all inputs are ignored.
//
// Build option (macro FIB_CHECK_HALT_ON_ERR_EN):
//   defined   - the first mismatch ends the run right away. The expected chain
//               advances on expected values only.
//   undefined - the run always consumes N_TERMS terms. The expected chain
//               resynchronises on the received data, so one corrupted term
//               gives mismatches at k, k+1 and k+2, and then checking
//               recovers.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   en         global enable
//   start      one-cycle pulse that begins a run; ignored unless idle
//   din_valid  din carries the next term this cycle
//   din        received term, DATA_W bits
//   busy       run in progress
//   done       one-cycle pulse when the run ends
//   err        sticky mismatch flag for the current or last run
//   err_cnt    mismatch count, saturating at 127
//   err_idx    index of the first mismatching term
//   term_cnt   terms accepted in the current or last run
//   fsm_state  debug view of the FSM state (0 IDLE, 1 RUN, 2 FIN)

module fib_stream_check #(
   parameter int                DATA_W  = 100,
   parameter int                N_TERMS = 100,
   parameter logic [DATA_W-1:0] SEED0   = '0,
   parameter logic [DATA_W-1:0] SEED1   = {{(DATA_W-1){1'b0}}, 1'b1}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [6:0]        err_cnt,
   output logic [6:0]        err_idx,
   output logic [6:0]        term_cnt,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [6:0] LAST_IDX = 7'(N_TERMS - 1);
   localparam logic [6:0] CNT_MAX  = 7'd127;

   state_t            state;
   logic [DATA_W-1:0] exp_pp;     // expected term n-2
   logic [DATA_W-1:0] exp_p;      // expected term n-1

   logic [DATA_W-1:0] exp_sum;
   logic [DATA_W-1:0] exp_cur;    // expected value of the term at index term_cnt
   logic [DATA_W-1:0] chain_val;  // value pushed into the expected chain
   logic              mismatch;
   logic              last_term;
   logic              end_run;

   assign fsm_state = state;

   always_comb begin
      exp_sum = exp_p + exp_pp;
      // The seeds sit pre-loaded in exp_pp/exp_p. Indices 0 and 1 compare
      // against them directly, and the sum is used from index 2 on.
      if (term_cnt == 7'd0) begin
         exp_cur = SEED0;
      end else if (term_cnt == 7'd1) begin
         exp_cur = SEED1;
      end else begin
         exp_cur = exp_sum;
      end

      mismatch  = (din != exp_cur);
      last_term = (term_cnt == LAST_IDX);

`ifdef FIB_CHECK_HALT_ON_ERR_EN
      chain_val = exp_cur;
      end_run   = last_term || mismatch;
`else
      // On a match din equals exp_cur. Always taking din is therefore the
      // same as resynchronising only after a mismatch.
      chain_val = din;
      end_run   = last_term;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= 7'd0;
         err_idx  <= 7'd0;
         term_cnt <= 7'd0;
         exp_pp   <= '0;
         exp_p    <= '0;
      end else if (en) begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  err      <= 1'b0;
                  err_cnt  <= 7'd0;
                  err_idx  <= 7'd0;
                  term_cnt <= 7'd0;
                  exp_pp   <= SEED0;
                  exp_p    <= SEED1;
                  busy     <= 1'b1;
                  state    <= S_RUN;
               end
            end

            S_RUN: begin
               if (din_valid) begin
                  term_cnt <= term_cnt + 7'd1;

                  // Indices 0 and 1 replace the seed slots in place. After
                  // that, the chain shifts by one term per acceptance.
                  if (term_cnt == 7'd0) begin
                     exp_pp <= chain_val;
                  end else if (term_cnt == 7'd1) begin
                     exp_p <= chain_val;
                  end else begin
                     exp_pp <= exp_p;
                     exp_p  <= chain_val;
                  end

                  if (mismatch) begin
                     err <= 1'b1;
                     if (err_cnt != CNT_MAX) begin
                        err_cnt <= err_cnt + 7'd1;
                     end
                     if (!err) begin
                        err_idx <= term_cnt;
                     end
                  end

                  if (end_run) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_FIN;
                  end
               end
            end

            S_FIN: begin
               // done is high for this one cycle. A start seen here is
               // ignored because the FSM only leaves IDLE on start.
               done  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fib_stream_check.sv
module tb_fib_stream_check;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   // Default-parameter instance (DATA_W=100, N_TERMS=100)
   logic        en = 1'b1;
   logic        start = 1'b0;
   logic        din_valid = 1'b0;
   logic [99:0] din = '0;
   logic        busy, done, err;
   logic [6:0]  err_cnt, err_idx, term_cnt;
   logic [1:0]  fsm_state;

   // Narrow instance for wrap-around (DATA_W=8, N_TERMS=20)
   logic        en8 = 1'b1;
   logic        start8 = 1'b0;
   logic        din_valid8 = 1'b0;
   logic [7:0]  din8 = '0;
   logic        busy8, done8, err8;
   logic [6:0]  err_cnt8, err_idx8, term_cnt8;
   logic [1:0]  fsm_state8;

   int check_cnt = 0;
   int pass_cnt  = 0;

   fib_stream_check dut (
      .clk(clk), .rst(rst), .en(en), .start(start),
      .din_valid(din_valid), .din(din),
      .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
      .err_idx(err_idx), .term_cnt(term_cnt), .fsm_state(fsm_state)
   );

   fib_stream_check #(.DATA_W(8), .N_TERMS(20)) dut8 (
      .clk(clk), .rst(rst), .en(en8), .start(start8),
      .din_valid(din_valid8), .din(din8),
      .busy(busy8), .done(done8), .err(err8), .err_cnt(err_cnt8),
      .err_idx(err_idx8), .term_cnt(term_cnt8), .fsm_state(fsm_state8)
   );

   // ---------------- driver helpers ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [99:0] fib(input int n);
      logic [99:0] a, b, t;
      a = '0;
      b = 100'd1;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic logic [99:0] rand100();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[99:0];
   endfunction

   // Pulses start in cycle 0 and then feeds terms 0..99 starting in cycle 1.
   // It stops when done is seen. lat is the cycle (counted from start) in
   // which done was seen, and sent is the number of terms presented.
   task automatic drive_run(input int corrupt_idx, input bit gaps, input int stall_at,
                            output int lat, output int sent, output bit timed_out);
      int  n;
      bit  phase;
      bit  stalled;
      n = 0; lat = 0; timed_out = 1'b1; phase = 1'b0; stalled = 1'b0;
      start = 1'b1; din_valid = 1'b0;
      tick;
      start = 1'b0;
      for (int cyc = 1; cyc < 1000; cyc++) begin
         if (done) begin
            lat = cyc;
            timed_out = 1'b0;
            break;
         end
         if (stall_at >= 0 && n == stall_at && !stalled) begin
            stalled = 1'b1;
            en = 1'b0;
            din_valid = 1'b1;
            din = rand100();
            repeat (5) tick;
            check_cnt++;
            if (term_cnt !== 7'(stall_at) || busy !== 1'b1)
               $display("FAIL en_stall_hold: term_cnt=%0d busy=%0b want term_cnt=%0d busy=1",
                        term_cnt, busy, stall_at);
            else pass_cnt++;
            en = 1'b1;
         end
         if (n < 100 && (!gaps || phase)) begin
            din_valid = 1'b1;
            din = fib(n) + ((n == corrupt_idx) ? 100'd1 : 100'd0);
            n++;
         end else begin
            din_valid = 1'b0;
            din = rand100();
         end
         phase = !phase;
         tick;
      end
      din_valid = 1'b0;
      sent = n;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
      check_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else pass_cnt++;
      check_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else pass_cnt++;
      check_cnt++; if (err_cnt !== 7'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      check_cnt++; if (err_idx !== 7'd0) $display("FAIL reset_err_idx: got %0d want 0", err_idx); else pass_cnt++;
      check_cnt++; if (term_cnt !== 7'd0) $display("FAIL reset_term_cnt: got %0d want 0", term_cnt); else pass_cnt++;
      check_cnt++; if (fsm_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", fsm_state); else pass_cnt++;
      check_cnt++; if (busy8 !== 1'b0 || term_cnt8 !== 7'd0) $display("FAIL reset_dut8: busy=%0b term_cnt=%0d want 0/0", busy8, term_cnt8); else pass_cnt++;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_clean_run;
      int lat, sent;
      bit to;
      drive_run(-1, 1'b0, -1, lat, sent, to);
      check_cnt++; if (to) $display("FAIL clean_timeout: no done within budget, want done"); else pass_cnt++;
      check_cnt++; if (lat != 101) $display("FAIL clean_done_cycle: got %0d want 101", lat); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL clean_busy_at_done: got %0b want 0", busy); else pass_cnt++;
      check_cnt++; if (term_cnt !== 7'd100) $display("FAIL clean_term_cnt: got %0d want 100", term_cnt); else pass_cnt++;
      check_cnt++; if (err !== 1'b0 || err_cnt !== 7'd0) $display("FAIL clean_err: err=%0b err_cnt=%0d want 0/0", err, err_cnt); else pass_cnt++;
   endtask

   // Runs on from test_clean_run, so we are in the done cycle here.
   task automatic test_back_to_back;
      start = 1'b1;                      // start in the done cycle is ignored
      tick;
      start = 1'b0;
      check_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_width: got %0b want 0", done); else pass_cnt++;
      check_cnt++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done: busy=%0b want 0", busy); else pass_cnt++;
      start = 1'b1;                      // earliest legal restart
      tick;
      start = 1'b0;
      check_cnt++; if (busy !== 1'b1 || term_cnt !== 7'd0) $display("FAIL b2b_restart: busy=%0b term_cnt=%0d want 1/0", busy, term_cnt); else pass_cnt++;
      // A start while busy must not restart the run
      din_valid = 1'b1; din = fib(0);
      tick;
      din = fib(1);
      start = 1'b1;
      tick;
      start = 1'b0; din_valid = 1'b0;
      check_cnt++; if (term_cnt !== 7'd2 || busy !== 1'b1) $display("FAIL b2b_start_while_busy: term_cnt=%0d busy=%0b want 2/1", term_cnt, busy); else pass_cnt++;
      // Abandon this run by reset.
      rst = 1'b1; tick; rst = 1'b0; tick;
   endtask

   task automatic test_corrupt;
      int lat, sent;
      bit to;
      drive_run(10, 1'b0, -1, lat, sent, to);
      check_cnt++; if (to) $display("FAIL corrupt_timeout: no done within budget, want done"); else pass_cnt++;
      check_cnt++; if (err !== 1'b1) $display("FAIL corrupt_err: got %0b want 1", err); else pass_cnt++;
      check_cnt++; if (err_idx !== 7'd10) $display("FAIL corrupt_err_idx: got %0d want 10", err_idx); else pass_cnt++;
`ifdef FIB_CHECK_HALT_ON_ERR_EN
      check_cnt++; if (lat != 12) $display("FAIL corrupt_done_cycle: got %0d want 12", lat); else pass_cnt++;
      check_cnt++; if (err_cnt !== 7'd1) $display("FAIL corrupt_err_cnt: got %0d want 1", err_cnt); else pass_cnt++;
      check_cnt++; if (term_cnt !== 7'd11) $display("FAIL corrupt_term_cnt: got %0d want 11", term_cnt); else pass_cnt++;
`else
      check_cnt++; if (lat != 101) $display("FAIL corrupt_done_cycle: got %0d want 101", lat); else pass_cnt++;
      check_cnt++; if (err_cnt !== 7'd3) $display("FAIL corrupt_err_cnt: got %0d want 3", err_cnt); else pass_cnt++;
      check_cnt++; if (term_cnt !== 7'd100) $display("FAIL corrupt_term_cnt: got %0d want 100", term_cnt); else pass_cnt++;
`endif
      tick;
   endtask

   task automatic test_gaps_stall;
      int lat, sent;
      bit to;
      drive_run(-1, 1'b1, 50, lat, sent, to);
      check_cnt++; if (to) $display("FAIL gaps_timeout: no done within budget, want done"); else pass_cnt++;
      check_cnt++; if (sent != 100) $display("FAIL gaps_early_done: done after %0d terms, want 100", sent); else pass_cnt++;
      check_cnt++; if (term_cnt !== 7'd100) $display("FAIL gaps_term_cnt: got %0d want 100", term_cnt); else pass_cnt++;
      check_cnt++; if (err !== 1'b0 || err_cnt !== 7'd0) $display("FAIL gaps_err: err=%0b err_cnt=%0d want 0/0", err, err_cnt); else pass_cnt++;
      tick;
   endtask

   task automatic test_reset_mid_run;
      int lat, sent;
      bit to;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         din_valid = 1'b1;
         din = fib(i) + ((i == 5) ? 100'd1 : 100'd0);
         tick;
      end
      din_valid = 1'b0;
      check_cnt++; if (err !== 1'b1 || err_idx !== 7'd5) $display("FAIL midrst_pre_err: err=%0b err_idx=%0d want 1/5", err, err_idx); else pass_cnt++;
`ifdef FIB_CHECK_HALT_ON_ERR_EN
      check_cnt++; if (term_cnt !== 7'd6 || busy !== 1'b0) $display("FAIL midrst_pre_cnt: term_cnt=%0d busy=%0b want 6/0", term_cnt, busy); else pass_cnt++;
`else
      check_cnt++; if (term_cnt !== 7'd50 || busy !== 1'b1) $display("FAIL midrst_pre_cnt: term_cnt=%0d busy=%0b want 50/1", term_cnt, busy); else pass_cnt++;
`endif
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check_cnt++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL midrst_flags: busy=%0b done=%0b err=%0b want 0/0/0", busy, done, err); else pass_cnt++;
      check_cnt++; if (err_cnt !== 7'd0 || err_idx !== 7'd0 || term_cnt !== 7'd0) $display("FAIL midrst_counts: err_cnt=%0d err_idx=%0d term_cnt=%0d want 0/0/0", err_cnt, err_idx, term_cnt); else pass_cnt++;
      tick;
      drive_run(-1, 1'b0, -1, lat, sent, to);
      check_cnt++; if (to || lat != 101) $display("FAIL midrst_rerun_done: timeout=%0b cycle=%0d want 0/101", to, lat); else pass_cnt++;
      check_cnt++; if (term_cnt !== 7'd100 || err !== 1'b0) $display("FAIL midrst_rerun_result: term_cnt=%0d err=%0b want 100/0", term_cnt, err); else pass_cnt++;
      tick;
   endtask

   task automatic test_wrap_8bit;
      logic [7:0] vec [20];
      int  lat;
      bit  seen;
      int  cidx;
      vec = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
              8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98, 8'd219, 8'd61, 8'd24, 8'd85};
      for (int r = 0; r < 2; r++) begin
         cidx = (r == 1) ? 14 : -1;        // second run: 121 sent as 122
         start8 = 1'b1;
         tick;
         start8 = 1'b0;
         seen = 1'b0; lat = 0;
         for (int c = 1; c < 200; c++) begin
            if (done8) begin
               seen = 1'b1;
               lat = c;
               break;
            end
            if (c <= 20) begin
               din_valid8 = 1'b1;
               din8 = vec[c-1] + (((c - 1) == cidx) ? 8'd1 : 8'd0);
            end else begin
               din_valid8 = 1'b0;
            end
            tick;
         end
         din_valid8 = 1'b0;
         check_cnt++; if (!seen) $display("FAIL wrap%0d_timeout: no done within budget, want done", r); else pass_cnt++;
         if (r == 0) begin
            check_cnt++; if (lat != 21 || term_cnt8 !== 7'd20) $display("FAIL wrap0_done: cycle=%0d term_cnt=%0d want 21/20", lat, term_cnt8); else pass_cnt++;
            check_cnt++; if (err8 !== 1'b0 || err_cnt8 !== 7'd0) $display("FAIL wrap0_err: err=%0b err_cnt=%0d want 0/0", err8, err_cnt8); else pass_cnt++;
         end else begin
            check_cnt++; if (err8 !== 1'b1 || err_idx8 !== 7'd14) $display("FAIL wrap1_err: err=%0b err_idx=%0d want 1/14", err8, err_idx8); else pass_cnt++;
`ifdef FIB_CHECK_HALT_ON_ERR_EN
            check_cnt++; if (err_cnt8 !== 7'd1 || term_cnt8 !== 7'd15) $display("FAIL wrap1_counts: err_cnt=%0d term_cnt=%0d want 1/15", err_cnt8, term_cnt8); else pass_cnt++;
`else
            check_cnt++; if (err_cnt8 !== 7'd3 || term_cnt8 !== 7'd20) $display("FAIL wrap1_counts: err_cnt=%0d term_cnt=%0d want 3/20", err_cnt8, term_cnt8); else pass_cnt++;
`endif
         end
         tick;
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_back_to_back();
      test_corrupt();
      test_gaps_stall();
      test_reset_mid_run();
      test_wrap_8bit();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
